// File: rtl/apb_regfile_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_regfile_bridge_pkg
// Shared types and helpers for the APB-to-regfile bridge.
//   state_t    : bridge FSM state encoding
//   CNT_W      : width of the read-latency down-counter
//   align_mask : byte-offset mask for a given data width (bits that must be
//                zero for a word-aligned address)
// -----------------------------------------------------------------------------
package apb_regfile_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int CNT_W = 2;

    function automatic int unsigned align_mask(input int unsigned data_w);
        return (data_w / 8) - 1;
    endfunction

endpackage

// File: rtl/apb_regfile_bridge.sv
// -----------------------------------------------------------------------------
// apb_regfile_bridge
// APB4 slave in front of xx_regfile. Each APB transfer becomes a single-cycle
// write or read request strobe towards the regfile; the regfile result is
// returned on pready/prdata/pslverr. One transfer is in flight at a time and
// wait states are inserted until the regfile result has been captured.
//
// Build option: APB_REGFILE_BRIDGE_PSLVERR_EN
//   defined   : pslverr reports the error flag in the response cycle
//   undefined : pslverr is held 0; erroneous reads still return prdata = 0
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   psel/penable/pwrite       APB control
//   paddr/pwdata/pstrb        APB address, write data, byte strobes
//   pready/prdata/pslverr     APB response (registered)
//   reg_wr_*_o, wr_data_vld_o regfile write port (registered)
//   invalid_wr_*/undefined_wr regfile write status flags
//   reg_rd_addr_o/reg_rd_req_o regfile read port (registered)
//   reg_rd_data_i, *_rd_*_i   regfile read data and status flags
//
// State table
//   state   | meaning
//   IDLE    | waiting for an APB setup phase
//   REQ     | request strobe to the regfile is high this cycle
//   WAIT    | read latency countdown (RD_LAT > 0 only)
//   RESP    | pready high for one cycle with prdata/pslverr
// -----------------------------------------------------------------------------
module apb_regfile_bridge
    import apb_regfile_bridge_pkg::*;
#(
    parameter int ADDR   = 16,
    parameter int DATA   = 32,
    parameter int RD_LAT = 1     // 0..3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR-1:0]     paddr,
    input  logic [DATA-1:0]     pwdata,
    input  logic [DATA/8-1:0]   pstrb,
    output logic                pready,
    output logic [DATA-1:0]     prdata,
    output logic                pslverr,
    output logic [ADDR-1:0]     reg_wr_addr_o,
    output logic [DATA-1:0]     reg_wr_data_o,
    output logic                wr_data_vld_o,
    output logic [DATA/8-1:0]   reg_wr_byte_en_o,
    output logic                reg_wr_req_o,
    input  logic                invalid_wr_addr_i,
    input  logic                invalid_wr_access_i,
    input  logic                undefined_wr_addr_i,
    output logic [ADDR-1:0]     reg_rd_addr_o,
    output logic                reg_rd_req_o,
    input  logic [DATA-1:0]     reg_rd_data_i,
    input  logic                valid_rd_addr_i,
    input  logic                invalid_rd_addr_i,
    input  logic                invalid_rd_access_i,
    input  logic                undefined_rd_addr_i
);

`ifdef APB_REGFILE_BRIDGE_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [ADDR-1:0]  ALIGN_MASK = ADDR'(align_mask(DATA));
    // Counter preload; the WAIT state exits when it reaches zero, so a load of
    // RD_LAT-1 gives exactly RD_LAT cycles between request and capture.
    localparam logic [CNT_W-1:0] LAT_LOAD   = (RD_LAT == 0) ? '0 : CNT_W'(RD_LAT - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic                r_pready;
    logic [DATA-1:0]     r_prdata;
    logic                r_pslverr;
    logic [ADDR-1:0]     r_wr_addr;
    logic [DATA-1:0]     r_wr_data;
    logic                r_wr_vld;
    logic [DATA/8-1:0]   r_wr_be;
    logic                r_wr_req;
    logic [ADDR-1:0]     r_rd_addr;
    logic                r_rd_req;

    logic                w_setup;
    logic                w_misaligned;
    logic                w_wr_err;
    logic                w_rd_err;

    assign w_setup      = psel & ~penable;
    assign w_misaligned = |(paddr & ALIGN_MASK);
    assign w_wr_err     = invalid_wr_addr_i | invalid_wr_access_i | undefined_wr_addr_i;
    assign w_rd_err     = ~valid_rd_addr_i | invalid_rd_addr_i | invalid_rd_access_i
                        | undefined_rd_addr_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_be   <= '0;
            r_wr_req  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_req  <= 1'b0;
        end else begin
            // Strobes and the response are single-cycle pulses by default.
            r_wr_req  <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_write <= pwrite;
                        if (w_misaligned) begin
                            r_state   <= ST_RESP;
                            r_pready  <= 1'b1;
                            r_pslverr <= ERR_EN;
                        end else begin
                            r_state <= ST_REQ;
                            if (pwrite) begin
                                r_wr_req  <= 1'b1;
                                r_wr_vld  <= 1'b1;
                                r_wr_addr <= paddr;
                                r_wr_data <= pwdata;
                                r_wr_be   <= pstrb;
                            end else begin
                                r_rd_req  <= 1'b1;
                                r_rd_addr <= paddr;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (r_write) begin
                        r_state   <= ST_RESP;
                        r_pready  <= 1'b1;
                        r_pslverr <= ERR_EN & w_wr_err;
                    end else if (RD_LAT == 0) begin
                        r_state   <= ST_RESP;
                        r_pready  <= 1'b1;
                        r_pslverr <= ERR_EN & w_rd_err;
                        r_prdata  <= w_rd_err ? '0 : reg_rd_data_i;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= LAT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_RESP;
                        r_pready  <= 1'b1;
                        r_pslverr <= ERR_EN & w_rd_err;
                        r_prdata  <= w_rd_err ? '0 : reg_rd_data_i;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // Return to IDLE even if the master dropped psel early.
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pready           = r_pready;
    assign prdata           = r_prdata;
    assign pslverr          = r_pslverr;
    assign reg_wr_addr_o    = r_wr_addr;
    assign reg_wr_data_o    = r_wr_data;
    assign wr_data_vld_o    = r_wr_vld;
    assign reg_wr_byte_en_o = r_wr_be;
    assign reg_wr_req_o     = r_wr_req;
    assign reg_rd_addr_o    = r_rd_addr;
    assign reg_rd_req_o     = r_rd_req;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_regfile_bridge
// Three bridge instances (RD_LAT = 0, 1, 3) share the APB bus signals and are
// selected individually by psel[k]. Each has a small regfile model that only
// presents valid read data/flags RD_LAT cycles after its read strobe and only
// presents clean write flags while its write strobe is high.
// -----------------------------------------------------------------------------
module tb_apb_regfile_bridge;

`ifdef APB_REGFILE_BRIDGE_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic        pready_a    [3];
    logic [31:0] prdata_a    [3];
    logic        pslverr_a   [3];
    logic [15:0] wr_addr_a   [3];
    logic [31:0] wr_data_a   [3];
    logic        wr_vld_a    [3];
    logic [3:0]  wr_be_a     [3];
    logic        wr_req_a    [3];
    logic [15:0] rd_addr_a   [3];
    logic        rd_req_a    [3];
    logic [31:0] rd_data_a   [3];
    logic        inv_wr_addr_a [3];
    logic        inv_wr_acc_a  [3];
    logic        undef_wr_a    [3];
    logic        valid_rd_a    [3];
    logic        inv_rd_addr_a [3];
    logic        inv_rd_acc_a  [3];
    logic        undef_rd_a    [3];

    logic [31:0] m_rdata    = 32'h0;
    logic        m_rd_undef = 1'b0;
    logic        m_wr_err   = 1'b0;
    logic        r1_dly     = 1'b0;
    logic [2:0]  r3_dly     = 3'b000;
    logic [2:0]  rd_vld;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r1_dly <= rd_req_a[1];
        r3_dly <= {r3_dly[1:0], rd_req_a[2]};
    end

    assign rd_vld[0] = rd_req_a[0];
    assign rd_vld[1] = r1_dly;
    assign rd_vld[2] = r3_dly[2];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rd_data_a[g]     = rd_vld[g] ? m_rdata : 32'hBAD0_BAD0;
        assign valid_rd_a[g]    = rd_vld[g] & ~m_rd_undef;
        assign undef_rd_a[g]    = rd_vld[g] & m_rd_undef;
        assign inv_rd_addr_a[g] = 1'b0;
        assign inv_rd_acc_a[g]  = 1'b0;
        assign inv_wr_addr_a[g] = ~wr_req_a[g];
        assign inv_wr_acc_a[g]  = wr_req_a[g] & m_wr_err;
        assign undef_wr_a[g]    = 1'b0;

        apb_regfile_bridge #(
            .ADDR   (16),
            .DATA   (32),
            .RD_LAT ((g == 0) ? 0 : (g == 1) ? 1 : 3)
        ) u_dut (
            .clk                 (clk),
            .rstn                (rstn),
            .psel                (psel[g]),
            .penable             (penable),
            .pwrite              (pwrite),
            .paddr               (paddr),
            .pwdata              (pwdata),
            .pstrb               (pstrb),
            .pready              (pready_a[g]),
            .prdata              (prdata_a[g]),
            .pslverr             (pslverr_a[g]),
            .reg_wr_addr_o       (wr_addr_a[g]),
            .reg_wr_data_o       (wr_data_a[g]),
            .wr_data_vld_o       (wr_vld_a[g]),
            .reg_wr_byte_en_o    (wr_be_a[g]),
            .reg_wr_req_o        (wr_req_a[g]),
            .invalid_wr_addr_i   (inv_wr_addr_a[g]),
            .invalid_wr_access_i (inv_wr_acc_a[g]),
            .undefined_wr_addr_i (undef_wr_a[g]),
            .reg_rd_addr_o       (rd_addr_a[g]),
            .reg_rd_req_o        (rd_req_a[g]),
            .reg_rd_data_i       (rd_data_a[g]),
            .valid_rd_addr_i     (valid_rd_a[g]),
            .invalid_rd_addr_i   (inv_rd_addr_a[g]),
            .invalid_rd_access_i (inv_rd_acc_a[g]),
            .undefined_rd_addr_i (undef_rd_a[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write and read strobes of one instance must never be high together.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            assert (!(wr_req_a[k] && rd_req_a[k])) else begin
                n_fail++;
                $error("FAIL overlap[%0d]: observed wr=%0b rd=%0b expected not both", k,
                       wr_req_a[k], rd_req_a[k]);
            end
        end
    end

    // Runs one APB transfer on instance k starting right now (just after a
    // rising edge). Leaves the bus idle just after the edge that ends RESP,
    // so a following call forms a back-to-back transfer.
    task automatic xfer(input int k, input bit wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int exp_cyc, input int exp_wr, input int exp_rd,
                        input logic [31:0] exp_rdata, input bit exp_err,
                        input string tag);
        int          cyc = 0;
        int          n_wr = 0;
        int          n_rd = 0;
        bit          done = 0;
        logic [15:0] s_wr_addr = '0;
        logic [31:0] s_wr_data = '0;
        logic [3:0]  s_wr_be = '0;
        logic        s_wr_vld = 1'b0;
        logic [15:0] s_rd_addr = '0;
        logic [31:0] g_rdata = '0;
        logic        g_err = 1'b0;
        psel    = '0;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (wr_req_a[k]) begin
                n_wr++;
                s_wr_addr = wr_addr_a[k];
                s_wr_data = wr_data_a[k];
                s_wr_be   = wr_be_a[k];
                s_wr_vld  = wr_vld_a[k];
            end
            if (rd_req_a[k]) begin
                n_rd++;
                s_rd_addr = rd_addr_a[k];
            end
            if (pready_a[k]) begin
                done    = 1;
                g_rdata = prdata_a[k];
                g_err   = pslverr_a[k];
            end
            @(posedge clk);
            #1;
            if (done) begin
                psel    = '0;
                penable = 1'b0;
            end else begin
                penable = 1'b1;
            end
        end
        psel    = '0;
        penable = 1'b0;
        check({tag, "/cycles"}, cyc, exp_cyc);
        check({tag, "/wr_pulses"}, n_wr, exp_wr);
        check({tag, "/rd_pulses"}, n_rd, exp_rd);
        check({tag, "/prdata"}, g_rdata, exp_rdata);
        check({tag, "/pslverr"}, {31'b0, g_err}, {31'b0, exp_err});
        if (exp_wr != 0) begin
            check({tag, "/wr_addr"}, {16'b0, s_wr_addr}, {16'b0, a});
            check({tag, "/wr_data"}, s_wr_data, d);
            check({tag, "/wr_be"}, {28'b0, s_wr_be}, {28'b0, s});
            check({tag, "/wr_vld"}, {31'b0, s_wr_vld}, 32'd1);
        end
        if (exp_rd != 0) begin
            check({tag, "/rd_addr"}, {16'b0, s_rd_addr}, {16'b0, a});
        end
    endtask

    initial begin
        rstn    = 1'b0;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst[%0d]/pready", k), {31'b0, pready_a[k]}, 32'd0);
            check($sformatf("rst[%0d]/prdata", k), prdata_a[k], 32'd0);
            check($sformatf("rst[%0d]/pslverr", k), {31'b0, pslverr_a[k]}, 32'd0);
            check($sformatf("rst[%0d]/wr_req", k), {31'b0, wr_req_a[k]}, 32'd0);
            check($sformatf("rst[%0d]/rd_req", k), {31'b0, rd_req_a[k]}, 32'd0);
            check($sformatf("rst[%0d]/wr_addr", k), {16'b0, wr_addr_a[k]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // RD_LAT = 1 instance
        xfer(1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 3, 1, 0, 32'h0, 1'b0, "wr_0010");
        m_rdata = 32'hDEAD_BEEF;
        xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, 4, 0, 1, 32'hDEAD_BEEF, 1'b0, "rd_0010");
        m_rdata    = 32'h1234_5678;
        m_rd_undef = 1'b1;
        xfer(1, 1'b0, 16'h00FC, 32'h0, 4'h0, 4, 0, 1, 32'h0, ERR_EN, "rd_undef");
        m_rd_undef = 1'b0;
        xfer(1, 1'b1, 16'h0012, 32'hCAFE_F00D, 4'hF, 2, 0, 0, 32'h0, ERR_EN, "wr_misal");
        m_wr_err = 1'b1;
        xfer(1, 1'b1, 16'h0020, 32'h0BAD_F00D, 4'h0, 3, 1, 0, 32'h0, ERR_EN, "wr_strb0_err");
        m_wr_err = 1'b0;
        xfer(1, 1'b1, 16'h0024, 32'h1122_3344, 4'h5, 3, 1, 0, 32'h0, 1'b0, "wr_be5");
        xfer(1, 1'b0, 16'h0101, 32'h0, 4'h0, 2, 0, 0, 32'h0, ERR_EN, "rd_misal");
        repeat (2) @(posedge clk);
        #1;

        // RD_LAT = 0, back-to-back reads
        m_rdata = 32'hA5A5_0001;
        xfer(0, 1'b0, 16'h0030, 32'h0, 4'h0, 3, 0, 1, 32'hA5A5_0001, 1'b0, "l0_rd0");
        m_rdata = 32'h5A5A_0002;
        xfer(0, 1'b0, 16'h0034, 32'h0, 4'h0, 3, 0, 1, 32'h5A5A_0002, 1'b0, "l0_rd1");

        // RD_LAT = 3, back-to-back reads
        m_rdata = 32'h3333_0003;
        xfer(2, 1'b0, 16'h0038, 32'h0, 4'h0, 6, 0, 1, 32'h3333_0003, 1'b0, "l3_rd0");
        m_rdata = 32'h4444_0004;
        xfer(2, 1'b0, 16'h003C, 32'h0, 4'h0, 6, 0, 1, 32'h4444_0004, 1'b0, "l3_rd1");

        // Reset while the RD_LAT = 3 instance sits in WAIT
        m_rdata = 32'h7777_8888;
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 16'h0040;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        check("mid_rst/rd_addr_before", {16'b0, rd_addr_a[2]}, 32'h0000_0040);
        rstn = 1'b0;
        #1;
        check("mid_rst/pready", {31'b0, pready_a[2]}, 32'd0);
        check("mid_rst/prdata", prdata_a[2], 32'd0);
        check("mid_rst/rd_req", {31'b0, rd_req_a[2]}, 32'd0);
        check("mid_rst/rd_addr", {16'b0, rd_addr_a[2]}, 32'd0);
        psel    = '0;
        penable = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        m_rdata = 32'h9999_AAAA;
        xfer(2, 1'b0, 16'h0044, 32'h0, 4'h0, 6, 0, 1, 32'h9999_AAAA, 1'b0, "post_rst_rd");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_regfile_bridge.md
Name: apb_regfile_bridge

Overview:
- APB4 slave that converts bus transfers into single-cycle request strobes on the xx_regfile write and read ports, and returns read data and errors as PREADY/PRDATA/PSLVERR.
- Sits directly upstream of xx_regfile, between the system APB interconnect and the register file.
- Serialises one transfer at a time and inserts wait states until the regfile result has been captured.

Parameters:
- ADDR, 16, address width; equals the regfile ADDR.
- DATA, 32, data width; must be a multiple of 8; equals the regfile DATA.
- RD_LAT, 1, cycles from reg_rd_req_o to valid reg_rd_data_i and read flags; legal range 0..3.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active-low
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1 = write
- paddr  in  ADDR  byte address
- pwdata  in  DATA  write data
- pstrb  in  DATA/8  write byte strobes
- pready  out  1  transfer complete
- prdata  out  DATA  read data
- pslverr  out  1  transfer error
- reg_wr_addr_o  out  ADDR  to regfile reg_wr_addr_i
- reg_wr_data_o  out  DATA  to reg_wr_data_i
- wr_data_vld_o  out  1  to wr_data_vld_i
- reg_wr_byte_en_o  out  DATA/8  to reg_wr_byte_en_i
- reg_wr_req_o  out  1  to reg_wr_req_i
- invalid_wr_addr_i, invalid_wr_access_i, undefined_wr_addr_i  in  1 each  regfile write flags
- reg_rd_addr_o  out  ADDR  to reg_rd_addr_i
- reg_rd_req_o  out  1  to reg_rd_req_i
- reg_rd_data_i  in  DATA  regfile read data
- valid_rd_addr_i, invalid_rd_addr_i, invalid_rd_access_i, undefined_rd_addr_i  in  1 each  regfile read flags

Behaviour:
- Single clock clk; reset rstn is asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - latency counter 0.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On psel & !penable (setup phase), latch paddr, pwdata, pstrb and pwrite.
  - If paddr is misaligned (low log2(DATA/8) bits nonzero), go to RESP with the error flag set and issue no regfile request.
  - Otherwise go to REQ.
- REQ:
  - Write: reg_wr_req_o = wr_data_vld_o = 1 for exactly this cycle; address, data and byte_en come from the latched values.
  - Write flags are sampled at the end of this cycle; next state is RESP.
  - Read: reg_rd_req_o = 1 for exactly this cycle.
  - RD_LAT == 0: sample reg_rd_data_i and the read flags at the end of this cycle; next state is RESP.
  - Otherwise load counter = RD_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter.
  - When the counter == 0, capture read data and flags; next state is RESP.
- RESP:
  - pready = 1 for exactly one cycle; prdata and pslverr are valid.
  - Next state is IDLE unconditionally, including when psel drops early (protocol violation; the response is dropped).
- Error flag:
  - Write: invalid_wr_addr_i | invalid_wr_access_i | undefined_wr_addr_i.
  - Read: !valid_rd_addr_i | invalid_rd_addr_i | invalid_rd_access_i | undefined_rd_addr_i.
  - Misaligned addresses also set the error flag.
- On a read error, prdata = 0. prdata is 0 outside RESP and for writes.
- Latency: a write completes in 3 cycles (setup, REQ, RESP). A read completes in 3+RD_LAT cycles.
- pstrb is forwarded unchanged, including all-zero strobes (the regfile ignores the write).
- Back-to-back transfers:
  - A new setup phase is accepted only in IDLE.
  - A setup arriving in the RESP cycle is seen in the following IDLE cycle, because APB holds psel.
- Reset mid-operation: request strobes drop immediately; the in-flight transfer is discarded.
- reg_wr_req_o and reg_rd_req_o are never asserted together.

Optional Feature:
- Macro: APB_REGFILE_BRIDGE_PSLVERR_EN.
- Defined: pslverr = error flag in RESP.
- Undefined: pslverr is tied 0. Erroneous reads still return prdata = 0. Erroneous writes complete silently.

Decomposition:
- Package apb_regfile_bridge_pkg holds:
  - the state enum typedef (IDLE/REQ/WAIT/RESP);
  - a localparam for counter width (2 bits);
  - a function for the alignment mask, derived from DATA.
- No sub-module; the FSM and capture registers form one flat module.

Test Plan:
- Write 0x0010 = 0xDEADBEEF, pstrb = 0xF, clean flags -> reg_wr_req_o pulses 1 cycle with addr 0x0010, byte_en 0xF; pready in cycle 3; pslverr = 0.
- Read 0x0010, RD_LAT = 1, regfile returns 0xDEADBEEF with valid_rd_addr_i = 1 -> reg_rd_req_o pulses 1 cycle; pready in cycle 4; prdata = 0xDEADBEEF; pslverr = 0.
- Read 0x00FC with undefined_rd_addr_i = 1 -> prdata = 0; pslverr = 1 with the macro defined, 0 without.
- Write 0x0012 (misaligned) -> no reg_wr_req_o; pready in cycle 2; pslverr = 1 with the macro defined.
- Sweep RD_LAT = 0 and RD_LAT = 3 with back-to-back reads -> pready at cycles 3 and 6 respectively; request strobes are never overlapped or duplicated.
- Assert rstn low during WAIT -> all outputs 0 asynchronously; after release, the next read completes normally.
